fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
Byte-serial instruction fetch sequencer for the processor front end.
- Drives the byte-wide, combinational-read instruction ROM one address per cycle.
- Assembles four consecutive bytes into a little-endian 32-bit instruction.
- Presents each instruction, with its PC, to decode over a valid/ready handshake.
- Handles fetch enable (stall) and PC redirect (branch/jump).

Parameters:
ADDRESS_WIDTH, 16, width of byte address and PC
RESET_PC, 0, byte address of first fetch after reset (must be a multiple of 4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  fetch enable; low pauses byte fetching
redirect  input  1  load new fetch PC this cycle
redirect_pc  input  ADDRESS_WIDTH  redirect target byte address
mem_addr  output  ADDRESS_WIDTH  byte address to ROM
mem_byte  input  8  ROM read data for mem_addr, same cycle
instr  output  32  assembled instruction, {byte3,byte2,byte1,byte0}
instr_pc  output  ADDRESS_WIDTH  byte address of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  consumer accepts instr

Behaviour:
- One clock, one synchronous active-high reset (clk, rst); all state updates on rising clk.
- Internal state: fetch_pc (AW bits), byte_cnt (2 bits), FSM {FETCH, VALID}, 32-bit assembly register.
- Reset values:
  - FSM=FETCH, fetch_pc=RESET_PC, byte_cnt=0.
  - instr_valid=0, instr=0, instr_pc=0, assembly register=0.
  - mem_addr therefore reads RESET_PC in the first cycle after reset.
- mem_addr = fetch_pc + byte_cnt, combinational, modulo 2^ADDRESS_WIDTH.
- FETCH with en=1:
  - Capture mem_byte into lane byte_cnt (lane 0 = bits 7:0); byte_cnt increments.
  - On the capture with byte_cnt==3:
    - instr <= {mem_byte, lanes 2..0}, instr_pc <= fetch_pc.
    - fetch_pc <= fetch_pc+4 (wraps modulo 2^ADDRESS_WIDTH), byte_cnt <= 0.
    - instr_valid <= 1, FSM <= VALID.
- FETCH with en=0: no capture; byte_cnt, fetch_pc and lanes hold. mem_addr stays stable.
- VALID:
  - instr, instr_pc and instr_valid hold stable while instr_ready=0. No ROM byte is captured; en is ignored.
  - instr_valid & instr_ready: transfer completes; instr_valid <= 0, FSM <= FETCH. The next byte capture occurs in the following cycle.
- Latency/throughput:
  - instr_valid rises on the edge ending the 4th FETCH cycle.
  - With en=1 and instr_ready=1 continuously, one instruction every 5 cycles.
- Redirect (priority below rst, above everything else):
  - fetch_pc <= {redirect_pc[AW-1:2], 2'b00} (low bits dropped, misaligned targets aligned down).
  - byte_cnt <= 0, FSM <= FETCH, instr_valid <= 0.
  - Partially assembled bytes are discarded; no byte is captured in the redirect cycle.
  - Redirect in the same cycle as instr_valid & instr_ready: the transfer counts as completed, then redirect applies.
  - Redirect while VALID without ready: the held word is dropped.
- Redirect with en=0: still applied; fetching resumes at the new PC when en rises.
- rst asserted mid-fetch or mid-VALID: all state returns to reset values on that edge, regardless of redirect/en/ready.
- Wrap-around: fetch_pc=2^AW-4 fetches the last 4 bytes; the next fetch_pc is 0.
- instr_pc records fetch_pc at word start. Byte addresses within a word wrap independently through mem_addr arithmetic.

Test Plan:
- ROM[0..7]=13 00 50 00 93 00 10 00, en=1, ready=1 after reset -> instr=0x00500013 pc=0x0000 valid on cycle 4 edge; instr=0x00100093 pc=0x0004 valid 5 cycles later; mem_addr sequence 0,1,2,3,(held),4,5,6,7.
- Same ROM, ready=0 for 6 cycles after first valid -> instr/instr_pc/valid stable 0x00500013/0; mem_addr held at 4; second word appears 5 cycles after ready rises.
- en dropped for 3 cycles after byte 1 captured -> mem_addr stays 0x0002; first word still 0x00500013, valid delayed exactly 3 cycles.
- redirect=1, redirect_pc=0x0006 while byte_cnt=2 -> next mem_addr=0x0004; partial bytes discarded; output instr=0x00100093 pc=0x0004.
- RESET_PC=0xFFFC, AW=16, ROM[FFFC..FFFF]=EF BE AD DE -> instr=0xDEADBEEF pc=0xFFFC; next mem_addr=0x0000, next instr_pc=0x0000.
- rst asserted in VALID with ready=0 and redirect=1 -> next cycle valid=0, instr=0, mem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Fetch-side bus: ROM byte port plus the instruction valid/ready handshake to decode.
interface fetch_seq_if #(
    parameter int unsigned ADDRESS_WIDTH = 16
) ();
    logic                     en;
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [7:0]               mem_byte;
    logic [31:0]              instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     instr_valid;
    logic                     instr_ready;

    // Sequencer side
    modport master (
        input  en, redirect, redirect_pc, mem_byte, instr_ready,
        output mem_addr, instr, instr_pc, instr_valid
    );

    // Environment side (ROM, decode, branch unit)
    modport slave (
        output en, redirect, redirect_pc, mem_byte, instr_ready,
        input  mem_addr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch: reads four ROM bytes per word, assembles a
// little-endian instruction and hands it to decode over valid/ready.
module fetch_seq #(
    parameter int unsigned             ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_seq_if.master bus
);
    localparam int unsigned AW = ADDRESS_WIDTH;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_fetch_pc;
    logic [1:0]    r_byte_cnt;
    // Lanes 0..2 only; lane 3 goes straight from mem_byte into the output word.
    logic [23:0]   r_lanes;
    logic [31:0]   r_instr;
    logic [AW-1:0] r_instr_pc;
    logic          r_instr_valid;
    logic [AW-1:0] w_mem_addr;

    // ROM address walks through the current word; wraps modulo 2^AW.
    assign w_mem_addr = r_fetch_pc + AW'(r_byte_cnt);

    assign bus.mem_addr    = w_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;

    // Fetch FSM: reset > redirect > byte capture / handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_fetch_pc    <= RESET_PC;
            r_byte_cnt    <= 2'd0;
            r_lanes       <= 24'd0;
            r_instr       <= 32'd0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (bus.redirect) begin
            // Target aligned down to a word; partial bytes and any held word are dropped.
            r_fetch_pc    <= {bus.redirect_pc[AW-1:2], 2'b00};
            r_byte_cnt    <= 2'd0;
            r_state       <= FETCH;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.en) begin
                        case (r_byte_cnt)
                            2'd0: r_lanes[7:0]   <= bus.mem_byte;
                            2'd1: r_lanes[15:8]  <= bus.mem_byte;
                            2'd2: r_lanes[23:16] <= bus.mem_byte;
                            default: begin
                                r_instr       <= {bus.mem_byte, r_lanes};
                                r_instr_pc    <= r_fetch_pc;
                                r_fetch_pc    <= r_fetch_pc + AW'(4);
                                r_instr_valid <= 1'b1;
                                r_state       <= VALID;
                            end
                        endcase
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                VALID: begin
                    if (bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: stimulus pushes expected words into per-DUT
// queues, monitors pop and compare on each completed transfer.
module tb_fetch_seq;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   base_a = 0;
    int   base_b = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
        int          rel;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [7:0] rom [0:65535];

    fetch_seq_if #(.ADDRESS_WIDTH(16)) ifa ();
    fetch_seq_if #(.ADDRESS_WIDTH(16)) ifb ();

    fetch_seq #(.ADDRESS_WIDTH(16), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa)
    );
    fetch_seq #(.ADDRESS_WIDTH(16), .RESET_PC(16'hFFFC)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb)
    );

    assign ifa.mem_byte = rom[ifa.mem_addr];
    assign ifb.mem_byte = rom[ifb.mem_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] i, input logic [15:0] p, input int r);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.rel   = r;
        return e;
    endfunction

    // Monitor A: every completed transfer must match the head of q_a.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst_a && ifa.instr_valid && ifa.instr_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_word", ifa.instr, 32'hxxxxxxxx);
            end else begin
                e = q_a.pop_front();
                chk("a_instr", ifa.instr, e.instr);
                chk("a_pc", 32'(ifa.instr_pc), 32'(e.pc));
                chk("a_cycle", 32'(cyc - base_a), 32'(e.rel));
            end
        end
    end

    // Monitor B: same for the wrap-around instance.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst_b && ifb.instr_valid && ifb.instr_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_word", ifb.instr, 32'hxxxxxxxx);
            end else begin
                e = q_b.pop_front();
                chk("b_instr", ifb.instr, e.instr);
                chk("b_pc", 32'(ifb.instr_pc), 32'(e.pc));
                chk("b_cycle", 32'(cyc - base_b), 32'(e.rel));
            end
        end
    end

    task automatic reset_a(input logic en, input logic ready);
        @(negedge clk);
        rst_a = 1'b1;
        ifa.redirect = 1'b0;
        ifa.redirect_pc = 16'h0;
        @(negedge clk);
        @(negedge clk);
        ifa.en = en;
        ifa.instr_ready = ready;
        rst_a = 1'b0;
        base_a = cyc;
    endtask

    task automatic wait_a(input int r);
        while (cyc - base_a < r) @(negedge clk);
    endtask

    task automatic wait_b(input int r);
        while (cyc - base_b < r) @(negedge clk);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_valid"}, 32'(ifa.instr_valid), 32'd0);
        chk({tag, "_instr"}, ifa.instr, 32'd0);
        chk({tag, "_pc"}, 32'(ifa.instr_pc), 32'd0);
        chk({tag, "_addr"}, 32'(ifa.mem_addr), 32'd0);
    endtask

    initial begin
        logic [15:0] seq [0:8];
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'h50; rom[3] = 8'h00;
        rom[4] = 8'h93; rom[5] = 8'h00; rom[6] = 8'h10; rom[7] = 8'h00;
        rom[16'hFFFC] = 8'hEF; rom[16'hFFFD] = 8'hBE;
        rom[16'hFFFE] = 8'hAD; rom[16'hFFFF] = 8'hDE;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.en = 1'b0; ifa.instr_ready = 1'b0; ifa.redirect = 1'b0; ifa.redirect_pc = 16'h0;
        ifb.en = 1'b0; ifb.instr_ready = 1'b0; ifb.redirect = 1'b0; ifb.redirect_pc = 16'h0;

        // T1: streaming fetch, one word every 5 cycles
        reset_a(1'b1, 1'b1);
        chk_reset_a("t1_reset");
        seq[0] = 16'd0; seq[1] = 16'd1; seq[2] = 16'd2; seq[3] = 16'd3; seq[4] = 16'd4;
        seq[5] = 16'd4; seq[6] = 16'd5; seq[7] = 16'd6; seq[8] = 16'd7;
        q_a.push_back(mk(32'h00500013, 16'h0000, 4));
        q_a.push_back(mk(32'h00100093, 16'h0004, 9));
        for (int r = 0; r < 9; r++) begin
            wait_a(r);
            chk($sformatf("t1_addr%0d", r), 32'(ifa.mem_addr), 32'(seq[r]));
        end
        wait_a(10);

        // T2: decode back-pressure holds the word and the ROM address
        reset_a(1'b1, 1'b0);
        q_a.push_back(mk(32'h00500013, 16'h0000, 10));
        q_a.push_back(mk(32'h00100093, 16'h0004, 15));
        for (int r = 4; r < 10; r++) begin
            wait_a(r);
            chk("t2_hold_valid", 32'(ifa.instr_valid), 32'd1);
            chk("t2_hold_instr", ifa.instr, 32'h00500013);
            chk("t2_hold_pc", 32'(ifa.instr_pc), 32'd0);
            chk("t2_hold_addr", 32'(ifa.mem_addr), 32'd4);
        end
        wait_a(10);
        ifa.instr_ready = 1'b1;
        wait_a(16);

        // T3: en low for 3 cycles after byte 1 captured delays valid by 3
        reset_a(1'b1, 1'b1);
        q_a.push_back(mk(32'h00500013, 16'h0000, 7));
        wait_a(2);
        ifa.en = 1'b0;
        for (int r = 2; r < 6; r++) begin
            wait_a(r);
            chk("t3_stall_addr", 32'(ifa.mem_addr), 32'd2);
            chk("t3_stall_valid", 32'(ifa.instr_valid), 32'd0);
        end
        ifa.en = 1'b1;
        wait_a(8);

        // T4: misaligned redirect mid-word discards partial bytes
        reset_a(1'b1, 1'b1);
        q_a.push_back(mk(32'h00100093, 16'h0004, 7));
        wait_a(2);
        chk("t4_pre_addr", 32'(ifa.mem_addr), 32'd2);
        ifa.redirect = 1'b1;
        ifa.redirect_pc = 16'h0006;
        wait_a(3);
        ifa.redirect = 1'b0;
        chk("t4_redirect_addr", 32'(ifa.mem_addr), 32'd4);
        wait_a(8);

        // T5: wrap-around from RESET_PC=0xFFFC
        @(negedge clk);
        ifb.en = 1'b1;
        ifb.instr_ready = 1'b1;
        rst_b = 1'b0;
        base_b = cyc;
        q_b.push_back(mk(32'hDEADBEEF, 16'hFFFC, 4));
        q_b.push_back(mk(32'h00500013, 16'h0000, 9));
        chk("t5_start_addr", 32'(ifb.mem_addr), 32'hFFFC);
        wait_b(5);
        chk("t5_wrap_addr", 32'(ifb.mem_addr), 32'd0);
        wait_b(10);
        rst_b = 1'b1;

        // T6: reset beats redirect while a word is held
        reset_a(1'b1, 1'b0);
        wait_a(5);
        chk("t6_held_valid", 32'(ifa.instr_valid), 32'd1);
        rst_a = 1'b1;
        ifa.redirect = 1'b1;
        ifa.redirect_pc = 16'h0010;
        wait_a(6);
        rst_a = 1'b0;
        ifa.redirect = 1'b0;
        chk_reset_a("t6_reset");

        repeat (3) @(negedge clk);
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
